// File: rtl/spike_rate_meter.sv
// Spike rate meter for a LIF neuron output: windowed edge count, inter-spike
// interval and running edge total, with a two-state IDLE/RUN control FSM.
module spike_rate_meter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spike,
    input  logic        ena,
    input  logic [7:0]  win_len,
    output logic [7:0]  rate,
    output logic        rate_valid,
    output logic [7:0]  isi,
    output logic        isi_valid,
    output logic [15:0] total
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        spike_d;
    logic [7:0]  wcnt;
    logic [7:0]  scnt;
    logic [7:0]  win_lat;
    logic [7:0]  isi_tmr;
    logic        armed;

    logic        start;
    logic        active;
    logic        stop;
    logic        spike_edge;
    logic        win_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ena)  state_nxt = RUN;
            RUN:     if (!ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A RUN cycle with ena low is the exit cycle: it counts nothing and emits nothing.
    always_comb begin
        start  = (state == IDLE) && ena;
        active = (state == RUN) && ena;
        stop   = (state == RUN) && !ena;
    end

    assign spike_edge = spike && !spike_d;
    assign win_end    = active && (wcnt == win_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spike_d <= 1'b0;
        else        spike_d <= spike;
    end

    // Window counting; win_lat only reloads at entry and at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= 8'd0;
            scnt       <= 8'd0;
            win_lat    <= 8'd0;
            rate       <= 8'd0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (start) begin
                win_lat <= win_len;
                wcnt    <= 8'd0;
                scnt    <= 8'd0;
            end else if (stop) begin
                wcnt <= 8'd0;
                scnt <= 8'd0;
            end else if (win_end) begin
                rate       <= scnt + {7'd0, spike_edge};
                rate_valid <= 1'b1;
                wcnt       <= 8'd0;
                scnt       <= 8'd0;
                win_lat    <= win_len;
            end else if (active) begin
                wcnt <= wcnt + 8'd1;
                if (spike_edge) scnt <= scnt + 8'd1;
            end
        end
    end

    // isi_tmr holds cycles elapsed since the last edge, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_tmr   <= 8'd0;
            armed     <= 1'b0;
            isi       <= 8'd0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (start) begin
                isi_tmr <= 8'd0;
                armed   <= 1'b0;
            end else if (stop) begin
                armed <= 1'b0;
            end else if (active) begin
                if (spike_edge) begin
                    isi_tmr <= 8'd1;
                    armed   <= 1'b1;
                    if (armed) begin
                        isi       <= isi_tmr;
                        isi_valid <= 1'b1;
                    end
                end else if (isi_tmr != 8'hFF) begin
                    isi_tmr <= isi_tmr + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= 16'd0;
        end else if (start) begin
            total <= 16'd0;
        end else if (active && spike_edge && (total != 16'hFFFF)) begin
            total <= total + 16'd1;
        end
    end

endmodule
